// File: rtl/spdif_subframe_source.sv
// spdif_subframe_source
// Buffers stereo pairs in a small FIFO and presents them to the S/PDIF frame
// encoder as alternating left/right subframes, with the consumer channel-status
// (C) bit indexed by the encoder's next subframe number. When the encoder's
// counter is cleared by an underrun, a pending right half is dropped so output
// resumes on a left subframe.

module spdif_subframe_source #(
    parameter int         audio_width    = 24,
    parameter int         fifo_depth     = 4,
    parameter logic       cs_copy_permit = 1'b1,
    parameter logic [7:0] cs_category    = 8'h00,
    parameter logic [3:0] cs_fs_code     = 4'b0010,
    parameter logic [1:0] cs_clock_acc   = 2'b00,
    parameter logic [3:0] cs_word_len    = 4'b1011
) (
    input  logic                          clk128,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [audio_width-1:0]        s_left,
    input  logic [audio_width-1:0]        s_right,
    input  logic [8:0]                    frame_number,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic                          o_is_left,
    output logic [audio_width-1:0]        o_audio,
    output logic                          o_user,
    output logic                          o_control,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic                          slip
);

    localparam int addr_width = $clog2(fifo_depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } phase_t;

    // Channel-status bit lookup: 192-bit consumer block, channel number
    // differs between the left and right subframes.
    function automatic logic cs_bit(input logic [7:0] idx, input logic is_left);
        logic [191:0] word;
        word         = '0;
        word[2]      = cs_copy_permit;
        word[15:8]   = cs_category;
        word[23:20]  = is_left ? 4'b0001 : 4'b0010;
        word[27:24]  = cs_fs_code;
        word[29:28]  = cs_clock_acc;
        word[35:32]  = cs_word_len;
        if (idx < 8'd192) begin
            cs_bit = word[idx];
        end else begin
            cs_bit = 1'b0;
        end
    endfunction

    // FIFO storage, entries packed as {left, right}
    logic [2*audio_width-1:0] mem_r [fifo_depth];
    logic [addr_width-1:0]    wr_ptr_r;
    logic [addr_width-1:0]    rd_ptr_r;
    logic [addr_width:0]      level_r;
    logic                     full_s;
    logic                     empty_s;
    logic                     wr_s;
    logic                     pop_s;
    logic [2*audio_width-1:0] head_s;

    // Output stage
    phase_t                   phase_r;
    phase_t                   phase_s;
    logic [audio_width-1:0]   right_r;
    logic [audio_width-1:0]   right_s;
    logic                     valid_s;
    logic                     is_left_s;
    logic [audio_width-1:0]   audio_s;
    logic                     slip_s;
    logic                     xfer_s;
    logic                     realign_s;

    assign full_s     = (level_r == (addr_width+1)'(fifo_depth));
    assign empty_s    = (level_r == '0);
    assign s_ready    = !full_s;
    assign wr_s       = s_valid && !full_s;
    assign head_s     = mem_r[rd_ptr_r];
    assign fifo_level = level_r;

    // The encoder only accepts a subframe whose parity matches its counter
    assign xfer_s     = o_valid && o_ready && (frame_number[0] == !o_is_left);
    // Counter cleared by underrun while a right half is pending
    assign realign_s  = (phase_r == RIGHT) && o_ready && !frame_number[0];

    assign o_user     = 1'b0;
    assign o_control  = cs_bit(frame_number[8:1], o_is_left);

    // FIFO data write (storage needs no reset; occupancy is tracked by level_r)
    always_ff @(posedge clk128) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {s_left, s_right};
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk128) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + addr_width'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + addr_width'(1'b1);
            end
            case ({wr_s, pop_s})
                2'b10:   level_r <= level_r + (addr_width+1)'(1'b1);
                2'b01:   level_r <= level_r - (addr_width+1)'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output-stage next state, next registered outputs and FIFO pop
    always_comb begin
        phase_s   = phase_r;
        right_s   = right_r;
        valid_s   = o_valid;
        is_left_s = o_is_left;
        audio_s   = o_audio;
        slip_s    = 1'b0;
        pop_s     = 1'b0;
        case (phase_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    phase_s   = LEFT;
                    right_s   = head_s[audio_width-1:0];
                    valid_s   = 1'b1;
                    is_left_s = 1'b1;
                    audio_s   = head_s[2*audio_width-1:audio_width];
                end else begin
                    valid_s   = 1'b0;
                    is_left_s = 1'b1;
                    audio_s   = '0;
                end
            end
            LEFT: begin
                if (xfer_s) begin
                    phase_s   = RIGHT;
                    valid_s   = 1'b1;
                    is_left_s = 1'b0;
                    audio_s   = right_r;
                end else begin
                    phase_s   = LEFT;
                end
            end
            RIGHT: begin
                if (xfer_s || realign_s) begin
                    slip_s = realign_s;
                    if (!empty_s) begin
                        pop_s     = 1'b1;
                        phase_s   = LEFT;
                        right_s   = head_s[audio_width-1:0];
                        valid_s   = 1'b1;
                        is_left_s = 1'b1;
                        audio_s   = head_s[2*audio_width-1:audio_width];
                    end else begin
                        phase_s   = IDLE;
                        valid_s   = 1'b0;
                        is_left_s = 1'b1;
                        audio_s   = '0;
                    end
                end else begin
                    phase_s = RIGHT;
                end
            end
            default: begin
                phase_s   = IDLE;
                valid_s   = 1'b0;
                is_left_s = 1'b1;
                audio_s   = '0;
            end
        endcase
    end

    // Output-stage state and registered outputs
    always_ff @(posedge clk128) begin
        if (reset) begin
            phase_r   <= IDLE;
            right_r   <= '0;
            o_valid   <= 1'b0;
            o_is_left <= 1'b1;
            o_audio   <= '0;
            slip      <= 1'b0;
        end else begin
            phase_r   <= phase_s;
            right_r   <= right_s;
            o_valid   <= valid_s;
            o_is_left <= is_left_s;
            o_audio   <= audio_s;
            slip      <= slip_s;
        end
    end

endmodule
